// File: rtl/oam_dma.sv
// Sprite DMA: snoops CPU writes to $4014, stalls the CPU and copies page $XX00-$XXFF to $2004.
// All other CPU bus traffic passes straight through while idle.
module oam_dma (
  input  logic        clk,
  input  logic        reset,
  input  logic        ce,
  input  logic [15:0] cpu_aout,
  input  logic [7:0]  cpu_dout,
  input  logic        cpu_mr,
  input  logic        cpu_mw,
  output logic        cpu_ce,
  output logic [15:0] bus_addr,
  output logic [7:0]  bus_dout,
  output logic        bus_mr,
  output logic        bus_mw,
  input  logic [7:0]  bus_din,
  output logic        busy
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_HALT,
    S_ALIGN,
    S_READ,
    S_WRITE
  } state_t;

  state_t     state_q, state_d;
  logic [7:0] page_q, page_d;
  logic [7:0] idx_q, idx_d;
  logic [7:0] data_q, data_d;
  logic       phase_q, phase_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      page_q  <= 8'h00;
      idx_q   <= 8'h00;
      data_q  <= 8'h00;
      phase_q <= 1'b0;
    end else if (ce) begin
      state_q <= state_d;
      page_q  <= page_d;
      idx_q   <= idx_d;
      data_q  <= data_d;
      phase_q <= phase_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    page_d   = page_q;
    idx_d    = idx_q;
    data_d   = data_q;
    phase_d  = ~phase_q;
    busy     = (state_q != S_IDLE);
    cpu_ce   = ce & ~busy;
    bus_addr = cpu_aout;
    bus_dout = cpu_dout;
    bus_mr   = 1'b0;
    bus_mw   = 1'b0;
    case (state_q)
      S_IDLE: begin
        bus_mr = cpu_mr;
        bus_mw = cpu_mw;
        // The triggering write itself still reaches the bus.
        if (cpu_mw && (cpu_aout == 16'h4014)) begin
          page_d  = cpu_dout;
          idx_d   = 8'h00;
          state_d = S_HALT;
        end
      end
      // Every READ must land on phase 0; ALIGN burns a cycle when needed.
      S_HALT:  state_d = phase_q ? S_READ : S_ALIGN;
      S_ALIGN: state_d = S_READ;
      S_READ: begin
        bus_addr = {page_q, idx_q};
        bus_mr   = 1'b1;
        data_d   = bus_din;
        state_d  = S_WRITE;
      end
      S_WRITE: begin
        bus_addr = 16'h2004;
        bus_dout = data_q;
        bus_mw   = 1'b1;
        if (idx_q == 8'hFF) begin
          state_d = S_IDLE;
        end else begin
          idx_d   = idx_q + 8'd1;
          state_d = S_READ;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

endmodule
